// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the complex sample type used by the
// SDF stages, and the bit-reversal helper used to address reorder memories.
package fft_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_LOG2N    = 4;
   localparam int BITREV_MAX_W = 16;

   typedef struct packed {
      logic signed [DEF_WIDTH-1:0] re;
      logic signed [DEF_WIDTH-1:0] im;
   } cplx_t;

   // Reverse the low nbits of idx; bits above nbits come back as zero.
   // Built from shifts so no variable bit-select is needed.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(
      input logic [BITREV_MAX_W-1:0] idx,
      input int                      nbits
   );
      logic [BITREV_MAX_W-1:0] res;
      logic [BITREV_MAX_W-1:0] tmp;
      res = '0;
      tmp = idx;
      for (int i = 0; i < BITREV_MAX_W; i++) begin
         if (i < nbits) begin
            res = {res[BITREV_MAX_W-2:0], tmp[0]};
            tmp = tmp >> 1;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle around the bit-reversal reorder block: bit-reversed
// samples in, natural-order samples out.
interface fft_bitrev_reorder_if
   import fft_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic                    enable_in;
   logic signed [WIDTH-1:0] in_re;
   logic signed [WIDTH-1:0] in_im;
   logic                    enable_out;
   logic signed [WIDTH-1:0] out_re;
   logic signed [WIDTH-1:0] out_im;
   logic                    frame_start;

   // Upstream / downstream side: drives samples in, observes the output stream.
   modport master (
      output enable_in, in_re, in_im,
      input  enable_out, out_re, out_im, frame_start
   );

   // Reorder block side.
   modport slave (
      input  enable_in, in_re, in_im,
      output enable_out, out_re, out_im, frame_start
   );

endinterface

// File: rtl/fft_reorder_ram.sv
// Simple dual-port memory holding both ping-pong banks; address is {bank, index}.
// Read data is registered; contents are not reset.
module fft_reorder_ram #(
   parameter int DW = 16,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_r [2**AW];

   // Write port: one word per enabled cycle.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port: data for rd_addr appears one edge later.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder for the SDF FFT output. Frames are
// written into alternating banks at bit-reversed addresses and read back
// sequentially, so consecutive frames stream out without gaps.
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LOG2N = DEF_LOG2N
) (
   input logic                clk,
   input logic                rst,
   fft_bitrev_reorder_if.slave bus
);

   localparam int N  = 1 << LOG2N;
   localparam int AW = LOG2N + 1;
   localparam int DW = 2 * WIDTH;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_READ = 1'b1
   } rd_state_t;

   // Write side
   logic [LOG2N-1:0]        wr_cnt_r;
   logic                    wr_bank_r;
   logic [LOG2N-1:0]        wr_idx_s;
   logic                    wr_last_s;

   // Bank bookkeeping
   logic [1:0]              full_r;
   logic [1:0]              full_next_s;
   logic [1:0]              rd_clr_s;
   logic [1:0]              wr_set_s;

   // Read side
   rd_state_t               rd_state_r;
   logic [LOG2N-1:0]        rd_cnt_r;
   logic                    rd_bank_r;
   logic                    rd_issue_s;
   logic                    rd_last_s;
   logic                    rd_valid_r;
   logic                    rd_first_r;
   logic [DW-1:0]           rd_data_s;

   // Output registers
   logic                    enable_out_r;
   logic                    frame_start_r;
   logic signed [WIDTH-1:0] out_re_r;
   logic signed [WIDTH-1:0] out_im_r;

   assign wr_idx_s  = LOG2N'(bitrev(BITREV_MAX_W'(wr_cnt_r), LOG2N));
   assign wr_last_s = bus.enable_in && (wr_cnt_r == LOG2N'(N - 1));

   // A read is issued every cycle in READ, and also straight from IDLE as soon
   // as the current bank is full; that IDLE issue is index 0 of the frame, which
   // is what keeps the input-to-output latency at two edges.
   assign rd_issue_s = (rd_state_r == S_READ) || full_r[rd_bank_r];
   assign rd_last_s  = rd_issue_s && (rd_cnt_r == LOG2N'(N - 1));

   // Flags as they will be after this edge: a finished read clears its bank, a
   // finished write sets its bank. The FSM looks at this to chain frames.
   assign rd_clr_s    = rd_last_s ? (2'b01 << rd_bank_r) : 2'b00;
   assign wr_set_s    = wr_last_s ? (2'b01 << wr_bank_r) : 2'b00;
   assign full_next_s = (full_r & ~rd_clr_s) | wr_set_s;

   fft_reorder_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (bus.enable_in),
      .wr_addr ({wr_bank_r, wr_idx_s}),
      .wr_data ({bus.in_re, bus.in_im}),
      .rd_en   (rd_issue_s),
      .rd_addr ({rd_bank_r, rd_cnt_r}),
      .rd_data (rd_data_s)
   );

   // Write counter and bank select: advance per accepted sample, flip bank at frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_r  <= '0;
         wr_bank_r <= 1'b0;
      end else if (bus.enable_in) begin
         wr_cnt_r  <= wr_cnt_r + LOG2N'(1);
         wr_bank_r <= wr_last_s ? ~wr_bank_r : wr_bank_r;
      end else begin
         wr_cnt_r  <= wr_cnt_r;
         wr_bank_r <= wr_bank_r;
      end
   end

   // Bank-full flags: set by the writer, cleared by the reader.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r <= 2'b00;
      end else begin
         full_r <= full_next_s;
      end
   end

   // Read FSM: sweeps natural indices of the full bank and tags each issued read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_r <= S_IDLE;
         rd_cnt_r   <= '0;
         rd_bank_r  <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_first_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_issue_s;
         rd_first_r <= rd_issue_s && (rd_cnt_r == '0);
         case (rd_state_r)
            S_IDLE: begin
               if (full_r[rd_bank_r]) begin
                  // Index 0 is issued on this edge; continue from index 1.
                  rd_state_r <= S_READ;
                  rd_cnt_r   <= LOG2N'(1);
               end else begin
                  rd_state_r <= S_IDLE;
                  rd_cnt_r   <= '0;
               end
            end
            S_READ: begin
               if (rd_last_s) begin
                  rd_cnt_r   <= '0;
                  rd_bank_r  <= ~rd_bank_r;
                  rd_state_r <= full_next_s[~rd_bank_r] ? S_READ : S_IDLE;
               end else begin
                  rd_cnt_r   <= rd_cnt_r + LOG2N'(1);
                  rd_state_r <= S_READ;
               end
            end
            default: begin
               rd_state_r <= S_IDLE;
               rd_cnt_r   <= '0;
            end
         endcase
      end
   end

   // Output register: forwards read data when valid, otherwise drives zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_out_r  <= 1'b0;
         frame_start_r <= 1'b0;
         out_re_r      <= '0;
         out_im_r      <= '0;
      end else if (rd_valid_r) begin
         enable_out_r  <= 1'b1;
         frame_start_r <= rd_first_r;
         out_re_r      <= rd_data_s[DW-1:WIDTH];
         out_im_r      <= rd_data_s[WIDTH-1:0];
      end else begin
         enable_out_r  <= 1'b0;
         frame_start_r <= 1'b0;
         out_re_r      <= '0;
         out_im_r      <= '0;
      end
   end

   assign bus.enable_out  = enable_out_r;
   assign bus.frame_start = frame_start_r;
   assign bus.out_re      = out_re_r;
   assign bus.out_im      = out_im_r;

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Output-side consumer of the SDF FFT pipeline. It accepts complex samples in bit-reversed order, qualified by the last stage's enable_out, and re-emits each N-point frame in natural order. Buffering is a ping-pong pair of N-entry banks, so back-to-back frames stream with no gaps. Sits directly after the final sdf stage, before any downstream magnitude or windowing logic.

Parameters:
WIDTH, 8, bit width of each real and imaginary sample (two's complement).
LOG2N, 4, log2 of the FFT frame length; N = 2**LOG2N.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
enable_in  input  1  input sample valid; driven by the last sdf stage's enable_out.
in_re  input  WIDTH  real part, signed, bit-reversed order.
in_im  input  WIDTH  imaginary part, signed, bit-reversed order.
enable_out  output  1  output sample valid.
out_re  output  WIDTH  real part, signed, natural order.
out_im  output  WIDTH  imaginary part, signed, natural order.
frame_start  output  1  high with natural index 0 of each output frame.

Behaviour:
- Reset: rst sampled high at a rising edge has the following effects.
  - enable_out, frame_start, out_re and out_im go to 0.
  - Write counter, write bank select and read counter go to 0.
  - Both bank-full flags are cleared and the reader goes idle.
  - Any partial input frame or in-progress output frame is discarded.
  - Memory contents are don't-care.
- Write side:
  - On each edge with enable_in=1, store {in_re, in_im} into bank wr_bank at address bitrev(wr_cnt), where bitrev reverses the LOG2N bits.
  - Then increment wr_cnt modulo N.
  - Cycles with enable_in=0 hold wr_cnt; gaps inside a frame are legal.
- Frame completion: when wr_cnt=N-1 is written, set full[wr_bank] and toggle wr_bank, both on the same edge.
- Read FSM states:
  - IDLE: no read in progress.
  - READ: rd_addr counts 0..N-1, one address per cycle, from bank rd_bank.
- IDLE -> READ: taken when full[rd_bank]=1; rd_addr starts at 0.
- Leaving READ after rd_addr=N-1 has been issued:
  - clear full[rd_bank] and toggle rd_bank;
  - if full on the new bank is already 1 (including a flag set on that same edge), continue directly with rd_addr=0 of the new bank, no idle cycle;
  - otherwise go to IDLE.
- Read data path:
  - Memory read is registered (one cycle), followed by an output register.
  - enable_out, frame_start and the data are aligned with each other.
  - frame_start=1 only together with natural index 0.
- Latency: if the last input sample of a frame is sampled at edge E, natural index 0 appears on the outputs after edge E+2. The remaining N-1 samples follow on consecutive cycles, with no holes, regardless of gaps in enable_in.
- No overrun by construction:
  - the reader drains one sample per cycle, and the writer writes at most one per cycle;
  - a bank's final read (edge E+N) always precedes the earliest rewrite of that bank (edge E+N+1).
  - The bench must still assert that a write never targets a bank with its full flag set.
- Idle output: when enable_out=0, out_re, out_im and frame_start are 0 (hold-zero, not hold-last).
- Width rule: data is passed through unmodified; there is no arithmetic, rounding or saturation.
- Reset mid-operation: outputs drop to 0 on the reset edge. The first frame after reset needs N fresh samples.

Decomposition:
- Shared package fft_pkg holds:
  - default WIDTH and LOG2N constants;
  - a bitrev function parameterised by LOG2N;
  - a complex-sample packed typedef {re, im}, reused by the sdf stages.
- One sub-module, fft_reorder_ram:
  - simple dual-port memory, 2*N words of 2*WIDTH bits;
  - one write port and one registered read port;
  - address = {bank, index}.
- Counters, full flags and the FSM stay in the top level.

Test Plan:
- Single frame, N=16: feed in_re = bitrev(k) (0,8,4,12,2,...,15) and in_im = -in_re for k=0..15 with enable_in continuously high. Required response: out_re = 0,1,...,15 and out_im = 0,-1,...,-15; enable_out high for exactly 16 cycles starting 2 edges after the last input; frame_start high only with out_re=0.
- Back-to-back: 3 consecutive frames with no gap, each frame offset by +16 in value. Required response: 48 consecutive enable_out cycles with no hole; frame_start at output sample positions 0, 16 and 32; values ascend 0..47 in natural order within each frame.
- Gapped input: one frame with enable_in toggling 1,0,1,0 (32 cycles). Required response: the output is still 16 contiguous cycles with the correct natural order; latency is 2 edges from the 16th accepted sample.
- Reset mid-frame: assert rst for 1 cycle after 9 samples, then feed a full new frame. Required response: no output from the partial frame; the new frame is output correctly; all outputs are 0 during and immediately after reset.
- Reset mid-output: assert rst while the 5th output sample is on the bus. Required response: enable_out=0 and out_re/out_im=0 from the next edge; remaining samples are never emitted.
- Extremes: values 127 and -128 in both re and im. Required response: passed through bit-exact; assertion of no write into a full bank holds throughout all tests.
